// File: rtl/button_bank.sv
// Multi-channel button/switch conditioner: two-flop sync, counter debounce, edge pulses.
// Define BUTTON_BANK_REPEAT_EN to add hold-to-repeat pulses on press.
module button_bank #(
  parameter int                  CHANNELS        = 5,
  parameter int                  DEBOUNCE_CYCLES = 650000,
  parameter int                  CNT_W           = 20,
  parameter logic [CHANNELS-1:0] INVERT          = {CHANNELS{1'b0}},
  parameter int                  REPEAT_DELAY    = 32500000,
  parameter int                  REPEAT_RATE     = 6500000,
  parameter int                  RPT_W           = 26
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press,
  output logic                any_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             s1_q, s1_d;
      logic             s2_q, s2_d;
      logic             clean_q, clean_d;
      logic             rise_q, rise_d;
      logic             fall_q, fall_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d    = noisy[gi] ^ INVERT[gi];
        s2_d    = s1_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == clean_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Edge pulses are registered alongside clean so they coincide with it.
          clean_d = s2_q;
          cnt_d   = '0;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          clean_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          clean_q <= clean_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
          cnt_q   <= cnt_d;
        end
      end

      assign clean[gi] = clean_q;
      assign rise[gi]  = rise_q;
      assign fall[gi]  = fall_q;

`ifdef BUTTON_BANK_REPEAT_EN
      localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

      logic [RPT_W-1:0] rc_q, rc_d;
      logic             phase_q, phase_d;   // 0: waiting initial delay, 1: repeating at rate
      logic             rpt_q, rpt_d;

      // A released or releasing channel holds the counter cleared, so a rise
      // always starts from rc = 0 in the delay phase.
      always_comb begin
        rc_d    = '0;
        phase_d = 1'b0;
        rpt_d   = 1'b0;
        if (clean_q && !fall_d) begin
          if (rc_q == (phase_q ? RATE_LAST : DELAY_LAST)) begin
            rpt_d   = 1'b1;
            phase_d = 1'b1;
          end else begin
            rc_d    = rc_q + 1'b1;
            phase_d = phase_q;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          rc_q    <= '0;
          phase_q <= 1'b0;
          rpt_q   <= 1'b0;
        end else begin
          rc_q    <= rc_d;
          phase_q <= phase_d;
          rpt_q   <= rpt_d;
        end
      end

      assign press[gi] = rise_q | rpt_q;
`else
      assign press[gi] = rise_q;
`endif
    end

`ifndef BUTTON_BANK_REPEAT_EN
    // Repeat parameters are accepted for interface compatibility but unused here.
    if (REPEAT_DELAY < 0 || REPEAT_RATE < 0 || RPT_W < 0) begin : g_rpt_unused
    end
`endif
  endgenerate

  assign any_rise = |rise;

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: CHANNELS=3, D=4, INVERT=3'b100, repeat 10/3.
// Edge 0 is the clock edge just before an input change; updates land at edge D+2.
module tb_button_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] noisy = 3'b100;
  logic [2:0] clean, rise, fall, press;
  logic       any_rise;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {clean, rise, fall, press, any_rise} per sampled cycle.
  logic [12:0] exp_q[$];
  logic [12:0] obs, expv;

`ifdef BUTTON_BANK_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  button_bank #(
    .CHANNELS(3), .DEBOUNCE_CYCLES(4), .CNT_W(3), .INVERT(3'b100),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .RPT_W(5)
  ) dut (
    .clock(clock), .reset(reset), .noisy(noisy), .clean(clean), .rise(rise),
    .fall(fall), .press(press), .any_rise(any_rise)
  );

  always #5 clock = ~clock;

  function automatic logic [12:0] pack(logic [2:0] c, logic [2:0] r, logic [2:0] f,
                                       logic [2:0] p);
    return {c, r, f, p, |r};
  endfunction

  // Leaves the bench at a negedge right after a reset edge with all channels idle.
  task automatic reset_idle();
    reset = 1'b1;
    noisy = 3'b100;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    noisy = 3'b100;
    for (int t = 1; t <= 2; t++) exp_q.push_back(13'd0);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_hold t=%0d got %b want %b", t, obs, expv);
      end
    end
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) exp_q.push_back(13'd0);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_release t=%0d got %b want %b", t, obs, expv);
      end
    end
    $display("test_reset: 12 cycles checked");
  endtask

  task automatic test_clean_press();
    reset_idle();
    noisy = 3'b101;
    for (int t = 1; t <= 18; t++) begin
      logic c0, r0, f0;
      c0 = (t >= 6) && (t < 15);
      r0 = (t == 6);
      f0 = (t == 15);
      exp_q.push_back(pack({2'b00, c0}, {2'b00, r0}, {2'b00, f0}, {2'b00, r0}));
    end
    for (int t = 1; t <= 18; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL clean_press t=%0d got %b want %b", t, obs, expv);
      end
      if (t == 9) noisy = 3'b100;
    end
    $display("test_clean_press: 18 cycles checked");
  endtask

  // Two sub-window pulses separated by one idle cycle: the counter must clear between them.
  task automatic test_glitch();
    reset_idle();
    noisy = 3'b110;
    for (int t = 1; t <= 14; t++) exp_q.push_back(13'd0);
    for (int t = 1; t <= 14; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL glitch t=%0d got %b want %b", t, obs, expv);
      end
      if (t == 3 || t == 7) noisy = 3'b100;
      if (t == 4) noisy = 3'b110;
    end
    $display("test_glitch: 14 cycles checked");
  endtask

  task automatic test_simultaneous();
    reset_idle();
    noisy = 3'b111;
    for (int t = 1; t <= 15; t++) begin
      logic [2:0] c, r;
      c = (t >= 6 ? 3'b011 : 3'b000) | (t >= 15 ? 3'b100 : 3'b000);
      r = (t == 6) ? 3'b011 : ((t == 15) ? 3'b100 : 3'b000);
      exp_q.push_back(pack(c, r, 3'b000, r));
    end
    for (int t = 1; t <= 15; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL simultaneous t=%0d got %b want %b", t, obs, expv);
      end
      if (t == 9) noisy = 3'b011;
    end
    $display("test_simultaneous: 15 cycles checked");
  endtask

  task automatic test_reset_mid();
    reset_idle();
    noisy = 3'b101;
    for (int t = 1; t <= 12; t++) begin
      logic c0, r0;
      c0 = (t >= 9);
      r0 = (t == 9);
      exp_q.push_back(pack({2'b00, c0}, {2'b00, r0}, 3'b000, {2'b00, r0}));
    end
    for (int t = 1; t <= 12; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_mid t=%0d got %b want %b", t, obs, expv);
      end
      if (t == 2) reset = 1'b1;
      if (t == 3) reset = 1'b0;
    end
    $display("test_reset_mid: 12 cycles checked");
  endtask

  task automatic test_repeat();
    reset_idle();
    noisy = 3'b101;
    for (int t = 1; t <= 36; t++) begin
      logic c0, r0, f0, p0;
      c0 = (t >= 6) && (t < 32);
      r0 = (t == 6);
      f0 = (t == 32);
      // Repeats at r+10, then every 3 cycles, while the button stays clean-high.
      p0 = r0 || (RPT && (t >= 16) && (t < 32) && (((t - 16) % 3) == 0));
      exp_q.push_back(pack({2'b00, c0}, {2'b00, r0}, {2'b00, f0}, {2'b00, p0}));
    end
    for (int t = 1; t <= 36; t++) begin
      @(negedge clock);
      obs = {clean, rise, fall, press, any_rise};
      expv = exp_q.pop_front();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL repeat t=%0d got %b want %b", t, obs, expv);
      end
      if (t == 26) noisy = 3'b100;
    end
    $display("test_repeat: 36 cycles checked (repeat build=%0d)", RPT);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
